// File: rtl/urp_pcie_tlp_rx_parser.sv
// -----------------------------------------------------------------------------
// urp_pcie_tlp_rx_parser
//
// RX-side TLP depacketizer. Takes a 32-bit dword stream from the link side
// (valid/ready with sop/eop framing), parses the 3DW or 4DW header, captures
// up to PAYLOAD_DW data dwords and holds one decoded TLP on the consumer
// interface until it is taken with tlp_valid_o/tlp_ready_i.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   rx_data_i/valid/sop/eop, rx_ready_o
//                         link-side dword stream
//   tlp_valid_o, tlp_ready_i
//                         decoded-TLP handshake
//   payload_o             captured data, first data DW in the top 32 bits
//   addr_o                address (DW2 for 3DW headers, DW3 for 4DW headers)
//   header_*_o            fmt/type/tc/length from DW0, requester/completer IDs
//                         from DW1
//   vc_o                  0 when tc is zero, else 1
//   err_type_o            type not one of 00000/00001/01010
//   err_len_o             framing did not match the header length
//   trunc_o               data dwords beyond PAYLOAD_DW were discarded
// -----------------------------------------------------------------------------
module urp_pcie_tlp_rx_parser #(
   parameter int PAYLOAD_DW = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [31:0]             rx_data_i,
   input  logic                    rx_valid_i,
   input  logic                    rx_sop_i,
   input  logic                    rx_eop_i,
   output logic                    rx_ready_o,
   output logic                    tlp_valid_o,
   input  logic                    tlp_ready_i,
   output logic [32*PAYLOAD_DW-1:0] payload_o,
   output logic [31:0]             addr_o,
   output logic [2:0]              header_fmt_o,
   output logic [4:0]              header_type_o,
   output logic [2:0]              header_tc_o,
   output logic [9:0]              header_length_o,
   output logic [15:0]             header_requestID_o,
   output logic [15:0]             header_completID_o,
   output logic                    vc_o,
   output logic                    err_type_o,
   output logic                    err_len_o,
   output logic                    trunc_o
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_H1   = 3'd1,
      S_H2   = 3'd2,
      S_H3   = 3'd3,
      S_DATA = 3'd4,
      S_DROP = 3'd5,
      S_OUT  = 3'd6
   } state_t;

   state_t                  r_state;
   logic                    r_rx_ready;
   logic                    r_tlp_valid;
   logic [32*PAYLOAD_DW-1:0] r_payload;
   logic [31:0]             r_addr;
   logic [2:0]              r_fmt;
   logic [4:0]              r_type;
   logic [2:0]              r_tc;
   logic [9:0]              r_len;
   logic [15:0]             r_req_id;
   logic [15:0]             r_cpl_id;
   logic                    r_vc;
   logic                    r_err_type;
   logic                    r_err_len;
   logic                    r_trunc;
   logic [10:0]             r_dcnt;   // index of the next data dword
   logic [10:0]             r_dtot;   // number of data dwords the header announces

   logic                    w_beat;
   logic                    w_type_ok;
   logic [10:0]             w_dtot;
   logic                    w_data_last;
   logic                    w_exp_last;
   state_t                  w_adv_state;

   assign w_beat    = rx_valid_i && r_rx_ready;
   assign w_type_ok = (rx_data_i[28:24] == 5'd0) || (rx_data_i[28:24] == 5'd1) ||
                      (rx_data_i[28:24] == 5'd10);
   // A length field of zero encodes 1024 dwords; header-only TLPs carry no data.
   assign w_dtot    = !rx_data_i[30]              ? 11'd0    :
                      (rx_data_i[9:0] == 10'd0)   ? 11'd1024 : {1'b0, rx_data_i[9:0]};
   assign w_data_last = (r_dcnt + 11'd1) == r_dtot;

   // Whether the current state's beat is the one the header says carries eop,
   // and where the parse goes next if it is neither last nor framed by eop.
   always_comb begin
      w_exp_last  = 1'b0;
      w_adv_state = r_state;
      case (r_state)
         S_H1:   w_adv_state = S_H2;
         S_H2: begin
            w_exp_last  = !r_fmt[0] && !r_fmt[1];
            w_adv_state = r_fmt[0] ? S_H3 : S_DATA;
         end
         S_H3: begin
            w_exp_last  = !r_fmt[1];
            w_adv_state = S_DATA;
         end
         S_DATA: w_exp_last = w_data_last;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_rx_ready  <= 1'b0;
         r_tlp_valid <= 1'b0;
         r_payload   <= '0;
         r_addr      <= '0;
         r_fmt       <= '0;
         r_type      <= '0;
         r_tc        <= '0;
         r_len       <= '0;
         r_req_id    <= '0;
         r_cpl_id    <= '0;
         r_vc        <= 1'b0;
         r_err_type  <= 1'b0;
         r_err_len   <= 1'b0;
         r_trunc     <= 1'b0;
         r_dcnt      <= '0;
         r_dtot      <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_rx_ready <= 1'b1;
               // Beats without sop are stray and silently dropped.
               if (w_beat && rx_sop_i) begin
                  r_fmt      <= rx_data_i[31:29];
                  r_type     <= rx_data_i[28:24];
                  r_tc       <= rx_data_i[22:20];
                  r_len      <= rx_data_i[9:0];
                  r_dtot     <= w_dtot;
                  r_vc       <= |rx_data_i[22:20];
                  r_err_type <= !w_type_ok;
                  r_payload  <= '0;
                  r_addr     <= '0;
                  r_req_id   <= '0;
                  r_cpl_id   <= '0;
                  r_err_len  <= 1'b0;
                  r_trunc    <= 1'b0;
                  r_dcnt     <= '0;
                  if (rx_eop_i) begin
                     // A single-dword TLP can never be complete.
                     r_err_len   <= 1'b1;
                     r_state     <= S_OUT;
                     r_tlp_valid <= 1'b1;
                     r_rx_ready  <= 1'b0;
                  end else begin
                     r_state <= S_H1;
                  end
               end
            end

            S_H1, S_H2, S_H3, S_DATA, S_DROP: begin
               if (w_beat) begin
                  // A fresh sop mid-packet is absorbed as ordinary data.
                  if (rx_sop_i) r_err_len <= 1'b1;

                  case (r_state)
                     S_H1: begin
                        r_req_id <= rx_data_i[31:16];
                        r_cpl_id <= rx_data_i[15:0];
                     end
                     S_H2: if (!r_fmt[0]) r_addr <= rx_data_i;
                     S_H3: r_addr <= rx_data_i;   // DW2 (upper address) is ignored
                     S_DATA: begin
                        for (int i = 0; i < PAYLOAD_DW; i++) begin
                           if (r_dcnt == 11'(i))
                              r_payload[32*(PAYLOAD_DW-1-i) +: 32] <= rx_data_i;
                        end
                        if (r_dcnt >= 11'(PAYLOAD_DW)) r_trunc <= 1'b1;
                        r_dcnt <= r_dcnt + 11'd1;
                     end
                     default: ;
                  endcase

                  if (rx_eop_i) begin
                     if (!w_exp_last && (r_state != S_DROP)) r_err_len <= 1'b1;
                     r_state     <= S_OUT;
                     r_tlp_valid <= 1'b1;
                     r_rx_ready  <= 1'b0;
                  end else if (w_exp_last) begin
                     // Packet runs past its announced length: swallow the rest.
                     r_err_len <= 1'b1;
                     r_state   <= S_DROP;
                  end else begin
                     r_state <= w_adv_state;
                  end
               end
            end

            S_OUT: begin
               r_rx_ready <= 1'b0;
               if (tlp_ready_i) begin
                  r_tlp_valid <= 1'b0;
                  r_rx_ready  <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign rx_ready_o         = r_rx_ready;
   assign tlp_valid_o        = r_tlp_valid;
   assign payload_o          = r_payload;
   assign addr_o             = r_addr;
   assign header_fmt_o       = r_fmt;
   assign header_type_o      = r_type;
   assign header_tc_o        = r_tc;
   assign header_length_o    = r_len;
   assign header_requestID_o = r_req_id;
   assign header_completID_o = r_cpl_id;
   assign vc_o               = r_vc;
   assign err_type_o         = r_err_type;
   assign err_len_o          = r_err_len;
   assign trunc_o            = r_trunc;

endmodule

// File: tb/tb_urp_pcie_tlp_rx_parser.sv
// -----------------------------------------------------------------------------
// tb_urp_pcie_tlp_rx_parser
//
// Self-checking bench for urp_pcie_tlp_rx_parser. Directed vectors from the
// block description plus randomized TLPs (random header fields, stray beats,
// early/late eop, stray sop) checked against a packet-level reference model.
// -----------------------------------------------------------------------------
module tb_urp_pcie_tlp_rx_parser;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [31:0]  rx_data;
   logic         rx_valid;
   logic         rx_sop;
   logic         rx_eop;
   logic         rx_ready_o;
   logic         tlp_valid_o;
   logic         tlp_ready;
   logic [127:0] payload_o;
   logic [31:0]  addr_o;
   logic [2:0]   header_fmt_o;
   logic [4:0]   header_type_o;
   logic [2:0]   header_tc_o;
   logic [9:0]   header_length_o;
   logic [15:0]  header_requestID_o;
   logic [15:0]  header_completID_o;
   logic         vc_o;
   logic         err_type_o;
   logic         err_len_o;
   logic         trunc_o;

   always #5 clk = ~clk;

   urp_pcie_tlp_rx_parser #(.PAYLOAD_DW(4)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .rx_data_i          (rx_data),
      .rx_valid_i         (rx_valid),
      .rx_sop_i           (rx_sop),
      .rx_eop_i           (rx_eop),
      .rx_ready_o         (rx_ready_o),
      .tlp_valid_o        (tlp_valid_o),
      .tlp_ready_i        (tlp_ready),
      .payload_o          (payload_o),
      .addr_o             (addr_o),
      .header_fmt_o       (header_fmt_o),
      .header_type_o      (header_type_o),
      .header_tc_o        (header_tc_o),
      .header_length_o    (header_length_o),
      .header_requestID_o (header_requestID_o),
      .header_completID_o (header_completID_o),
      .vc_o               (vc_o),
      .err_type_o         (err_type_o),
      .err_len_o          (err_len_o),
      .trunc_o            (trunc_o)
   );

   typedef struct packed {
      logic [127:0] payload;
      logic [31:0]  addr;
      logic [2:0]   fmt;
      logic [4:0]   typ;
      logic [2:0]   tc;
      logic [9:0]   len;
      logic [15:0]  req;
      logic [15:0]  cpl;
      logic         vc;
      logic         err_type;
      logic         err_len;
      logic         trunc;
   } tlp_t;

   int n_cmp = 0;
   int n_err = 0;

   // Beats of the TLP under test; the last entry carries eop.
   logic [31:0] q_dw[$];
   bit          q_sop[$];

   function automatic tlp_t snap();
      tlp_t s;
      s.payload  = payload_o;
      s.addr     = addr_o;
      s.fmt      = header_fmt_o;
      s.typ      = header_type_o;
      s.tc       = header_tc_o;
      s.len      = header_length_o;
      s.req      = header_requestID_o;
      s.cpl      = header_completID_o;
      s.vc       = vc_o;
      s.err_type = err_type_o;
      s.err_len  = err_len_o;
      s.trunc    = trunc_o;
      return s;
   endfunction

   // Packet-level model: what a decoded TLP should look like given the beats
   // that arrive from sop up to and including eop.
   function automatic tlp_t model();
      tlp_t        r;
      int          n, hn, nd, got;
      logic [31:0] d0;
      r  = '0;
      n  = q_dw.size();
      d0 = q_dw[0];
      r.fmt      = d0[31:29];
      r.typ      = d0[28:24];
      r.tc       = d0[22:20];
      r.len      = d0[9:0];
      r.vc       = (r.tc != 3'd0);
      r.err_type = !(r.typ inside {5'd0, 5'd1, 5'd10});
      hn = r.fmt[0] ? 4 : 3;
      nd = !r.fmt[1] ? 0 : ((r.len == 10'd0) ? 1024 : int'(r.len));
      r.err_len = (n != hn + nd);
      for (int i = 1; i < n; i++) if (q_sop[i]) r.err_len = 1'b1;
      if (n >= 2)  {r.req, r.cpl} = q_dw[1];
      if (n >= hn) r.addr = q_dw[hn-1];
      got = n - hn;
      if (got < 0)  got = 0;
      if (got > nd) got = nd;
      for (int k = 0; k < got && k < 4; k++) r.payload[127-32*k -: 32] = q_dw[hn+k];
      r.trunc = (got > 4);
      return r;
   endfunction

   task automatic send_beat(input logic [31:0] d, input bit s, input bit e);
      int t;
      if ($urandom_range(0, 3) == 0) begin
         @(negedge clk);
         rx_valid = 1'b0;
      end
      @(negedge clk);
      rx_data  = d;
      rx_sop   = s;
      rx_eop   = e;
      rx_valid = 1'b1;
      t = 0;
      while (!rx_ready_o && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!rx_ready_o) begin
         n_cmp++;
         n_err++;
         $display("FAIL beat_accept: rx_ready_o stayed 0 for %0d cycles, required 1", t);
      end
      @(posedge clk);
   endtask

   task automatic send_tlp();
      for (int i = 0; i < q_dw.size(); i++)
         send_beat(q_dw[i], q_sop[i], i == q_dw.size() - 1);
   endtask

   task automatic load_tlp(input int v);
      q_dw.delete();
      q_sop.delete();
      case (v)
         1: q_dw = '{32'h40000004, 32'hABCD0000, 32'h12345678, 32'hDEADBEEF,
                     32'hCAFEBABE, 32'h0, 32'h0};
         2: q_dw = '{32'h2A500008, 32'h12345678, 32'h00000000, 32'h87654321};
         3: begin
            q_dw = '{32'h61300010, 32'hFFFF0000, 32'h0, 32'h0000FFFF,
                     32'h3456C0FF, 32'hEE123456};
            for (int i = 0; i < 14; i++) q_dw.push_back(32'h0);
         end
         4: q_dw = '{32'h39100008, 32'h12345678, 32'h0, 32'h1000FFFF};
         5: q_dw = '{32'h40000004, 32'hABCD0000, 32'h12345678, 32'hDEADBEEF};
         default: q_dw = '{32'h0};
      endcase
      for (int i = 0; i < q_dw.size(); i++) q_sop.push_back(i == 0);
   endtask

   function automatic tlp_t spec_expect(input int v);
      tlp_t e;
      e = '0;
      case (v)
         1: begin
            e.payload = {32'hDEADBEEF, 32'hCAFEBABE, 64'h0};
            e.addr = 32'h12345678; e.fmt = 3'b010; e.len = 10'd4; e.req = 16'hABCD;
         end
         2: begin
            e.addr = 32'h87654321; e.fmt = 3'b001; e.typ = 5'b01010; e.tc = 3'b101;
            e.len = 10'd8; e.req = 16'h1234; e.cpl = 16'h5678; e.vc = 1'b1;
         end
         3: begin
            e.payload = {32'h3456C0FF, 32'hEE123456, 64'h0};
            e.addr = 32'h0000FFFF; e.fmt = 3'b011; e.typ = 5'b00001; e.tc = 3'b011;
            e.len = 10'd16; e.req = 16'hFFFF; e.vc = 1'b1; e.trunc = 1'b1;
         end
         4: begin
            e.addr = 32'h1000FFFF; e.fmt = 3'b001; e.typ = 5'b11001; e.tc = 3'b001;
            e.len = 10'd8; e.req = 16'h1234; e.cpl = 16'h5678; e.vc = 1'b1;
            e.err_type = 1'b1;
         end
         default: ;
      endcase
      return e;
   endfunction

   task automatic test_reset();
      rst_n     = 1'b0;
      rx_data   = 32'h40000004;
      rx_sop    = 1'b1;
      rx_eop    = 1'b0;
      rx_valid  = 1'b1;
      tlp_ready = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (snap() !== tlp_t'('0)) begin
         n_err++;
         $display("FAIL reset_outputs: got %h required 0", snap());
      end
      n_cmp++;
      if (rx_ready_o !== 1'b0 || tlp_valid_o !== 1'b0) begin
         n_err++;
         $display("FAIL reset_handshake: rx_ready_o=%b tlp_valid_o=%b required 0/0",
                  rx_ready_o, tlp_valid_o);
      end
      rx_valid = 1'b0;
      rx_sop   = 1'b0;
      rst_n    = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (rx_ready_o !== 1'b1 || tlp_valid_o !== 1'b0) begin
         n_err++;
         $display("FAIL idle_after_reset: rx_ready_o=%b tlp_valid_o=%b required 1/0",
                  rx_ready_o, tlp_valid_o);
      end
      $display("reset: done");
   endtask

   task automatic test_spec_vectors();
      tlp_t exp, obs;
      for (int v = 1; v <= 4; v++) begin
         load_tlp(v);
         exp = spec_expect(v);
         send_tlp();
         @(negedge clk);
         rx_valid = 1'b0;
         n_cmp++;
         if (tlp_valid_o !== 1'b1) begin
            n_err++;
            $display("FAIL vec%0d_latency: tlp_valid_o=%b required 1", v, tlp_valid_o);
         end
         obs = snap();
         n_cmp++;
         if (obs !== exp) begin
            n_err++;
            $display("FAIL vec%0d_fields: got %h required %h", v, obs, exp);
         end
         n_cmp++;
         if (rx_ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL vec%0d_ready_in_out: rx_ready_o=%b required 0", v, rx_ready_o);
         end
         tlp_ready = 1'b1;
         @(negedge clk);
         tlp_ready = 1'b0;
         n_cmp++;
         if (tlp_valid_o !== 1'b0 || rx_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL vec%0d_release: tlp_valid_o=%b rx_ready_o=%b required 0/1",
                     v, tlp_valid_o, rx_ready_o);
         end
         $display("vector T%0d: fields %h", v, obs);
      end
   endtask

   task automatic test_early_eop_hold();
      tlp_t exp, held;
      load_tlp(5);
      exp = spec_expect(1);
      exp.payload = {32'hDEADBEEF, 96'h0};
      exp.err_len = 1'b1;
      send_tlp();
      @(negedge clk);
      rx_valid = 1'b0;
      held = snap();
      n_cmp++;
      if (tlp_valid_o !== 1'b1 || held !== exp) begin
         n_err++;
         $display("FAIL early_eop: valid=%b got %h required %h", tlp_valid_o, held, exp);
      end
      // A competing sop beat is offered while the result is held; it must be ignored.
      rx_data  = 32'h6A7FFFFF;
      rx_sop   = 1'b1;
      rx_eop   = 1'b1;
      rx_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         n_cmp++;
         if (snap() !== held || tlp_valid_o !== 1'b1 || rx_ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL hold_cycle%0d: valid=%b ready=%b got %h required %h",
                     c, tlp_valid_o, rx_ready_o, snap(), held);
         end
      end
      rx_valid  = 1'b0;
      tlp_ready = 1'b1;
      @(negedge clk);
      tlp_ready = 1'b0;
      n_cmp++;
      if (tlp_valid_o !== 1'b0 || rx_ready_o !== 1'b1) begin
         n_err++;
         $display("FAIL hold_release: tlp_valid_o=%b rx_ready_o=%b required 0/1",
                  tlp_valid_o, rx_ready_o);
      end
      $display("early eop + hold: fields %h", held);
   endtask

   task automatic test_reset_mid();
      tlp_t exp, obs;
      load_tlp(1);
      send_beat(q_dw[0], 1'b1, 1'b0);
      send_beat(q_dw[1], 1'b0, 1'b0);
      @(negedge clk);
      rx_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      n_cmp++;
      if (snap() !== tlp_t'('0) || tlp_valid_o !== 1'b0 || rx_ready_o !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mid: valid=%b ready=%b got %h required 0",
                  tlp_valid_o, rx_ready_o, snap());
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      load_tlp(2);
      exp = spec_expect(2);
      send_tlp();
      @(negedge clk);
      rx_valid = 1'b0;
      obs = snap();
      n_cmp++;
      if (tlp_valid_o !== 1'b1 || obs !== exp) begin
         n_err++;
         $display("FAIL after_reset_T2: valid=%b got %h required %h", tlp_valid_o, obs, exp);
      end
      tlp_ready = 1'b1;
      @(negedge clk);
      tlp_ready = 1'b0;
      $display("reset mid-TLP then T2: fields %h", obs);
   endtask

   task automatic test_back_to_back();
      tlp_t exp, obs;
      tlp_ready = 1'b1;
      for (int v = 1; v <= 2; v++) begin
         load_tlp(v == 1 ? 4 : 1);
         exp = model();
         send_tlp();
         @(negedge clk);
         rx_valid = 1'b0;
         obs = snap();
         n_cmp++;
         if (tlp_valid_o !== 1'b1 || rx_ready_o !== 1'b0 || obs !== exp) begin
            n_err++;
            $display("FAIL b2b_%0d: valid=%b ready=%b got %h required %h",
                     v, tlp_valid_o, rx_ready_o, obs, exp);
         end
         @(negedge clk);
         n_cmp++;
         if (tlp_valid_o !== 1'b0 || rx_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_%0d_bubble: tlp_valid_o=%b rx_ready_o=%b required 0/1",
                     v, tlp_valid_o, rx_ready_o);
         end
         $display("back-to-back %0d: fields %h", v, obs);
      end
      tlp_ready = 1'b0;
   endtask

   task automatic build_random(input int iter);
      logic [31:0] dw0;
      logic [2:0]  fmt;
      logic [4:0]  typ;
      logic [9:0]  len;
      int          hn, nd, total, n, mode;
      dw0 = $urandom;
      fmt = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
         0: typ = 5'd0;
         1: typ = 5'd1;
         2: typ = 5'd10;
         default: typ = 5'($urandom);
      endcase
      len = 10'($urandom_range(1, 9));
      if (iter == 0) begin
         fmt = 3'b010;
         len = 10'd0;
      end
      dw0[31:29] = fmt;
      dw0[28:24] = typ;
      dw0[9:0]   = len;
      hn    = fmt[0] ? 4 : 3;
      nd    = !fmt[1] ? 0 : ((len == 10'd0) ? 1024 : int'(len));
      total = hn + nd;
      mode  = (iter == 0) ? 0 : $urandom_range(0, 9);
      if (mode <= 6)      n = total;
      else if (mode <= 8) n = $urandom_range(1, total - 1);
      else                n = total + $urandom_range(1, 3);
      q_dw.delete();
      q_sop.delete();
      q_dw.push_back(dw0);
      q_sop.push_back(1'b1);
      for (int i = 1; i < n; i++) begin
         q_dw.push_back($urandom);
         q_sop.push_back($urandom_range(0, 19) == 0);
      end
   endtask

   task automatic test_random();
      tlp_t exp, obs;
      int   hold;
      for (int it = 0; it < 60; it++) begin
         // Stray beats while idle must not start or disturb a TLP.
         repeat ($urandom_range(0, 2)) send_beat($urandom, 1'b0, 1'($urandom_range(0, 1)));
         build_random(it);
         exp = model();
         send_tlp();
         @(negedge clk);
         rx_valid = 1'b0;
         obs = snap();
         n_cmp++;
         if (tlp_valid_o !== 1'b1 || obs !== exp) begin
            n_err++;
            $display("FAIL random_%0d: valid=%b got %h required %h", it, tlp_valid_o, obs, exp);
         end
         hold = $urandom_range(0, 2);
         repeat (hold) @(negedge clk);
         n_cmp++;
         if (tlp_valid_o !== 1'b1 || rx_ready_o !== 1'b0 || snap() !== exp) begin
            n_err++;
            $display("FAIL random_%0d_hold: valid=%b ready=%b got %h required %h",
                     it, tlp_valid_o, rx_ready_o, snap(), exp);
         end
         tlp_ready = 1'b1;
         @(negedge clk);
         tlp_ready = 1'b0;
         $display("random %0d: beats=%0d fields %h", it, q_dw.size(), obs);
      end
   endtask

   initial begin
      test_reset();
      test_spec_vectors();
      test_early_eop_hold();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
